// File: rtl/econet_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | econet_pkg                                                            |
// | Shared constants, FSM encoding and CRC step for the Econet receiver.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package econet_pkg;

    localparam logic [7:0]  FLAG     = 8'h7E;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h8408;
    localparam logic [15:0] FCS_GOOD = 16'hF0B8;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        RX   = 2'd2
    } rx_state_t;

    // One LSB-first step of the reflected CRC-CCITT register.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[0] ^ b;
        return fb ? ((crc >> 1) ^ CRC_POLY) : (crc >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/econet_hdlc_rx_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | econet_hdlc_rx_if                                                     |
// | Serial line input and byte/frame strobes of the HDLC receiver.        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface econet_hdlc_rx_if;

    logic        rx;
    logic        inhibit;
    logic [7:0]  rx_byte;
    logic [15:0] rx_fcs;
    logic        rx_byte_ready;
    logic        rx_frame_start;
    logic        rx_frame_end;
    logic        receiving;

    modport master (
        output rx, inhibit,
        input  rx_byte, rx_fcs, rx_byte_ready, rx_frame_start, rx_frame_end, receiving
    );

    modport slave (
        input  rx, inhibit,
        output rx_byte, rx_fcs, rx_byte_ready, rx_frame_start, rx_frame_end, receiving
    );

endinterface
`default_nettype wire

// File: rtl/econet_crc16.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | econet_crc16                                                          |
// | Bit-serial CRC-CCITT register; init restarts it from CRC_INIT.        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module econet_crc16
    import econet_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        init,
    input  wire logic        bit_en,
    input  wire logic        i_bit,
    output logic [15:0]      o_crc
);

    // init together with bit_en folds the first bit into a fresh register,
    // so the previous frame's value stays visible until then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_crc <= CRC_INIT;
        end else if (init) begin
            o_crc <= bit_en ? crc_step(CRC_INIT, i_bit) : CRC_INIT;
        end else if (bit_en) begin
            o_crc <= crc_step(o_crc, i_bit);
        end
    end

endmodule
`default_nettype wire

// File: rtl/econet_hdlc_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | econet_hdlc_rx                                                        |
// | Flag hunt, zero destuffing, LSB-first byte assembly and FCS check.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module econet_hdlc_rx
    import econet_pkg::*;
#(
    parameter int MIN_FRAME_BYTES = 2
) (
    input  wire logic       econet_clk,
    input  wire logic       reset,
    econet_hdlc_rx_if.slave bus
);

    localparam logic [2:0] c_min_bytes = 3'(MIN_FRAME_BYTES);

    logic [6:0] r_raw;
    logic [2:0] r_ones;
    logic [6:0] r_dly;
    logic [2:0] r_fill;
    logic [6:0] r_shift;
    logic [2:0] r_bitcnt;
    logic [2:0] r_bytecnt;
    rx_state_t  r_state;
    rx_state_t  w_state_next;

    logic [7:0] w_raw;
    logic       w_flag;
    logic       w_abort;
    logic       w_stuffed;
    logic       w_push;
    logic       w_data;
    logic       w_exit_bit;
    logic       w_start;
    logic       w_end;

    assign w_raw      = {bus.rx, r_raw};
    assign w_flag     = (w_raw == FLAG);
    assign w_abort    = bus.rx && (r_ones >= 3'd6);
    assign w_stuffed  = !bus.rx && (r_ones == 3'd5);
    assign w_push     = !w_stuffed && !w_flag && !w_abort;
    // Seven stored bits plus the incoming one: the oldest leaves as data.
    assign w_exit_bit = r_dly[6];
    assign w_data     = w_push && (r_fill == 3'd7) && (r_state != HUNT) && !bus.inhibit;

    always_ff @(posedge econet_clk or posedge reset) begin
        if (reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_end        = 1'b0;
        if (bus.inhibit || w_abort) begin
            w_state_next = HUNT;
        end else begin
            case (r_state)
                HUNT: begin
                    if (w_flag) w_state_next = SYNC;
                end
                SYNC: begin
                    if (w_data) begin
                        w_state_next = RX;
                        w_start      = 1'b1;
                    end
                end
                RX: begin
                    if (w_flag) begin
                        w_state_next = SYNC;
                        w_end        = (r_bitcnt == 3'd0) && (r_bytecnt >= c_min_bytes);
                    end
                end
                default: w_state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge econet_clk or posedge reset) begin
        if (reset) begin
            r_raw              <= '0;
            r_ones             <= '0;
            r_dly              <= '0;
            r_fill             <= '0;
            r_shift            <= '0;
            r_bitcnt           <= '0;
            r_bytecnt          <= '0;
            bus.rx_byte        <= 8'h00;
            bus.rx_byte_ready  <= 1'b0;
            bus.rx_frame_start <= 1'b0;
            bus.rx_frame_end   <= 1'b0;
            bus.receiving      <= 1'b0;
        end else begin
            r_raw              <= w_raw[7:1];
            r_ones             <= bus.rx ? ((r_ones == 3'd7) ? 3'd7 : r_ones + 3'd1) : 3'd0;
            bus.rx_frame_start <= w_start;
            bus.rx_frame_end   <= w_end;
            bus.rx_byte_ready  <= 1'b0;
            bus.receiving      <= (w_state_next == RX);

            if (w_flag) begin
                r_dly     <= '0;
                r_fill    <= '0;
                r_bitcnt  <= '0;
                r_bytecnt <= '0;
            end else if (w_push) begin
                r_dly <= {r_dly[5:0], bus.rx};
                if (r_fill != 3'd7) r_fill <= r_fill + 3'd1;
            end

            if (w_data) begin
                r_shift  <= {w_exit_bit, r_shift[6:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                    bus.rx_byte       <= {w_exit_bit, r_shift};
                    bus.rx_byte_ready <= 1'b1;
                    if (r_bytecnt != 3'd7) r_bytecnt <= r_bytecnt + 3'd1;
                end
            end
        end
    end

    econet_crc16 u_crc (
        .clk    (econet_clk),
        .rst    (reset),
        .init   (w_start),
        .bit_en (w_data),
        .i_bit  (w_exit_bit),
        .o_crc  (bus.rx_fcs)
    );

endmodule
`default_nettype wire
